// File: rtl/ula_arbiter.sv
// Round-robin arbiter that time-shares one combinational ULA between two requesters.
// One operation in flight: accept in IDLE, drive the ULA for one EXEC cycle, hold the response in RESP.
module ula_arbiter #(
  parameter int   WIDTH   = 32,
  parameter logic RR_INIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   ula_in1,
  output logic [WIDTH-1:0]   ula_in2,
  output logic [3:0]         ula_op,
  input  logic [WIDTH-1:0]   ula_result,
  input  logic               ula_zero,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, err_q, err_d;
  logic             gnt_vld, gnt_idx;
  logic [1:0]       ready_int;

  function automatic logic is_illegal(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h6, 4'h7,
      4'hB, 4'hC, 4'hD, 4'hE, 4'hF: is_illegal = 1'b0;
      default:                      is_illegal = 1'b1;
    endcase
  endfunction

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_vld = |req_valid;
    gnt_idx = 1'b0;
    case (req_valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant_q;
      default: gnt_idx = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    zero_d       = zero_q;
    err_d        = err_q;
    ready_int    = 2'b00;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          ready_int[gnt_idx] = 1'b1;
          op_d         = gnt_idx ? req_op[7:4] : req_op[3:0];
          a_d          = gnt_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          b_d          = gnt_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          owner_d      = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = ula_result;
        zero_d   = ula_zero;
        err_d    = is_illegal(op_q);
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= RR_INIT;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
    end
  end

  // Ready is combinational, so it is masked while reset is held to keep it low.
  assign req_ready  = rst_n ? ready_int : 2'b00;
  assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign ula_in1    = a_q;
  assign ula_in2    = b_q;
  assign ula_op     = op_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a behavioural ULA attached to the ula_* ports.
module tb_ula_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]       req_op;
  logic [63:0]      req_a, req_b;
  logic [31:0]      rsp_result, ula_in1, ula_in2, ula_result;
  logic             rsp_zero, rsp_err, ula_zero, busy;
  logic [3:0]       ula_op;

  int checks = 0;
  int passed = 0;

  ula_arbiter #(.WIDTH(WIDTH), .RR_INIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .ula_in1(ula_in1), .ula_in2(ula_in2), .ula_op(ula_op),
    .ula_result(ula_result), .ula_zero(ula_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ULA; unsupported opcodes fall through to ADD.
  always_comb begin
    case (ula_op)
      4'h0:    ula_result = ula_in1 & ula_in2;
      4'h1:    ula_result = ula_in1 | ula_in2;
      4'h6:    ula_result = ula_in1 - ula_in2;
      4'h7:    ula_result = {31'd0, $signed(ula_in1) < $signed(ula_in2)};
      4'hB:    ula_result = {ula_in2[15:0], 16'd0};
      4'hC:    ula_result = ~(ula_in1 | ula_in2);
      4'hD:    ula_result = ula_in1 ^ ula_in2;
      4'hE:    ula_result = ula_in2 << ula_in1[4:0];
      4'hF:    ula_result = ula_in2 >> ula_in1[4:0];
      default: ula_result = ula_in1 + ula_in2;
    endcase
    ula_zero = (ula_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[idx]           = 1'b1;
    req_op[idx*4 +: 4]       = op;
    req_a[idx*32 +: 32]      = a;
    req_b[idx*32 +: 32]      = b;
  endtask

  // Called just after a falling edge with requests already set up.
  // hold = cycles the owner keeps rsp_ready low while the other bit toggles.
  task automatic serve(input int own, input logic [31:0] res, input logic zf, input logic er,
                       input int hold);
    #1;
    chk("req_ready", 32'(req_ready), 32'(2'b01 << own));
    @(posedge clk); #1;
    req_valid[own] = 1'b0;
    @(negedge clk);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << own));
      chk("rsp_result", rsp_result, res);
      chk("rsp_zero", 32'(rsp_zero), 32'(zf));
      chk("rsp_err", 32'(rsp_err), 32'(er));
      if (i < hold) rsp_ready[1-own] = ~rsp_ready[1-own];
      else          rsp_ready[own] = 1'b1;
      @(posedge clk);
    end
    #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    set_req(1, 4'h2, 32'd1, 32'd1);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ula_op", 32'(ula_op), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Single op with operand visibility during EXEC
    set_req(0, 4'h2, 32'd5, 32'd7);
    #1;
    chk("single_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("exec_in1", ula_in1, 32'd5);
    chk("exec_in2", ula_in2, 32'd7);
    chk("exec_op", 32'(ula_op), 32'd2);
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_result", rsp_result, 32'd12);
    chk("single_zero", 32'(rsp_zero), 32'd0);
    chk("single_err", 32'(rsp_err), 32'd0);
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_hold_in1", ula_in1, 32'd5);

    // Tie after reset: 0,1 then 0,1 again
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 4'h6, 32'd9, 32'd4);
    set_req(1, 4'h1, 32'hF0, 32'h0F);
    serve(0, 32'd5, 1'b0, 1'b0, 0);
    serve(1, 32'hFF, 1'b0, 1'b0, 0);
    set_req(0, 4'h0, 32'hFF00, 32'h0FF0);
    set_req(1, 4'hD, 32'hAAAA, 32'h5555);
    serve(0, 32'h0F00, 1'b0, 1'b0, 0);
    serve(1, 32'hFFFF, 1'b0, 1'b0, 0);

    // Zero flag under back-pressure
    set_req(1, 4'h6, 32'd3, 32'd3);
    serve(1, 32'd0, 1'b1, 1'b0, 4);

    // Illegal opcode, then a legal op clears the error
    set_req(0, 4'h3, 32'd2, 32'd3);
    serve(0, 32'd5, 1'b0, 1'b1, 0);
    set_req(0, 4'h2, 32'd1, 32'd1);
    serve(0, 32'd2, 1'b0, 1'b0, 0);

    // Shifts and LUI
    set_req(0, 4'hE, 32'd4, 32'd1);
    serve(0, 32'd16, 1'b0, 1'b0, 0);
    set_req(0, 4'hB, 32'd0, 32'h0000ABCD);
    serve(0, 32'hABCD0000, 1'b0, 1'b0, 0);
    set_req(0, 4'hF, 32'd4, 32'h100);
    serve(0, 32'h10, 1'b0, 1'b0, 0);

    // Reset during EXEC
    set_req(0, 4'h2, 32'd1, 32'd2);
    #1;
    chk("mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_exec_busy", 32'(busy), 32'd1);
    set_req(1, 4'hD, 32'hFF, 32'h0F);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_in1", ula_in1, 32'd0);
    chk("mid_rst_op", 32'(ula_op), 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    serve(1, 32'hF0, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
